// File: rtl/scariv_pkg.sv
// Shared scheduler types and sizes for the scariv CSU issue path.
package scariv_pkg;

  localparam int CSU_ENTRY_SIZE = 8;
  localparam int CSU_IDX_W      = $clog2(CSU_ENTRY_SIZE);

  // Index plus one wrap bit, so full and empty can be told apart.
  typedef logic [CSU_IDX_W:0] csu_sched_ptr_t;

endpackage : scariv_pkg

// File: rtl/scariv_oldest_oh_picker.sv
// One-hot grant to the first request at or after a one-hot base position, with wrap.
// Rotates the request vector to the base, takes the lowest set bit, rotates the grant back.
module scariv_oldest_oh_picker #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [WIDTH-1:0] i_base_oh,
  output logic [WIDTH-1:0] o_grant_oh,
  output logic             o_valid
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] w_base_idx;
  logic [WIDTH-1:0] w_req_rot;
  logic [WIDTH-1:0] w_grant_rot;

  // NOTE: the default before the loop keeps this block purely combinational; without it
  // the index would hold its old value when no bit is set and a latch would be inferred.
  always_comb begin
    w_base_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_base_oh[i]) w_base_idx = i[IDX_W-1:0];
    end
  end

  // A shift by WIDTH yields zero, so base index 0 needs no special case.
  assign w_req_rot   = (i_req >> w_base_idx) | (i_req << (WIDTH - int'(w_base_idx)));
  assign w_grant_rot = w_req_rot & (~w_req_rot + WIDTH'(1));
  assign o_grant_oh  = (w_grant_rot << w_base_idx) |
                       (w_grant_rot >> (WIDTH - int'(w_base_idx)));
  assign o_valid     = |i_req;

endmodule : scariv_oldest_oh_picker

// File: rtl/scariv_csu_sched_ctrl.sv
// CSU scheduler controller: in-order allocate at the in-pointer, oldest-first pick,
// and strictly in-order retire at the out-pointer with one credit per retire.
module scariv_csu_sched_ctrl
  import scariv_pkg::*;
#(
  parameter  int ENTRY_SIZE = CSU_ENTRY_SIZE,
  localparam int IDX_W      = $clog2(ENTRY_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_disp_valid,
  output logic                  o_disp_ready,
  output logic [ENTRY_SIZE-1:0] o_put,
  output logic [ENTRY_SIZE-1:0] o_out_ptr_valid,
  input  logic [ENTRY_SIZE-1:0] i_entry_valid,
  input  logic [ENTRY_SIZE-1:0] i_entry_ready,
  input  logic                  i_pipe_stall,
  output logic [ENTRY_SIZE-1:0] o_entry_picked,
  output logic                  o_pick_valid,
  output logic [IDX_W-1:0]      o_pick_idx,
  input  logic [ENTRY_SIZE-1:0] i_issue_succeeded,
  output logic [ENTRY_SIZE-1:0] o_clear_entry,
  output logic                  o_credit_return,
  output logic [IDX_W:0]        o_free_cnt
);

  localparam logic [IDX_W:0] PTR_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] FREE_MAX = (IDX_W+1)'(ENTRY_SIZE);

  logic [IDX_W:0]        r_in_ptr;
  logic [IDX_W:0]        r_out_ptr;
  logic [IDX_W:0]        r_free_cnt;
  logic [IDX_W:0]        w_free_next;
  logic [IDX_W-1:0]      w_in_idx;
  logic [IDX_W-1:0]      w_out_idx;
  logic                  w_empty;
  logic                  w_alloc;
  logic                  w_retire;
  logic [ENTRY_SIZE-1:0] w_pick_req;

  assign w_in_idx  = r_in_ptr[IDX_W-1:0];
  assign w_out_idx = r_out_ptr[IDX_W-1:0];
  assign w_empty   = (r_in_ptr == r_out_ptr);

  assign o_free_cnt      = r_free_cnt;
  assign o_disp_ready    = (r_free_cnt != '0);
  assign w_alloc         = i_disp_valid & o_disp_ready;
  assign o_put           = {ENTRY_SIZE{w_alloc}} & (ENTRY_SIZE'(1) << w_in_idx);
  assign o_out_ptr_valid = ENTRY_SIZE'(1) << w_out_idx;

  assign w_pick_req = i_entry_valid & i_entry_ready & ~{ENTRY_SIZE{i_pipe_stall}};

  scariv_oldest_oh_picker #(
    .WIDTH (ENTRY_SIZE)
  ) u_picker (
    .i_req      (w_pick_req),
    .i_base_oh  (o_out_ptr_valid),
    .o_grant_oh (o_entry_picked),
    .o_valid    (o_pick_valid)
  );

  always_comb begin
    o_pick_idx = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (o_entry_picked[i]) o_pick_idx = i[IDX_W-1:0];
    end
  end

  // Only the oldest entry may release; the empty guard blocks a stale success strobe.
  assign o_clear_entry   = o_out_ptr_valid & i_issue_succeeded & {ENTRY_SIZE{~w_empty}};
  assign w_retire        = |o_clear_entry;
  assign o_credit_return = w_retire;

  always_comb begin
    w_free_next = r_free_cnt;
    case ({w_retire, w_alloc})
      2'b10:   w_free_next = r_free_cnt + PTR_ONE;
      2'b01:   w_free_next = r_free_cnt - PTR_ONE;
      default: w_free_next = r_free_cnt;
    endcase
  end

  // NOTE: non-blocking assignments let every register sample pre-edge values, so the
  // pointers and free count update together regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_ptr   <= '0;
      r_out_ptr  <= '0;
      r_free_cnt <= FREE_MAX;
    end else begin
      if (w_alloc)  r_in_ptr  <= r_in_ptr + PTR_ONE;
      if (w_retire) r_out_ptr <= r_out_ptr + PTR_ONE;
      r_free_cnt <= w_free_next;
    end
  end

  a_no_put_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !o_disp_ready |-> (o_put == '0));

  a_free_in_range: assert property (@(posedge i_clk) disable iff (i_reset)
    r_free_cnt <= FREE_MAX);

endmodule : scariv_csu_sched_ctrl

// File: tb/tb_scariv_csu_sched_ctrl.sv
// Directed bench for scariv_csu_sched_ctrl: allocate, pick, retire, wrap, flush drain, reset.
module tb_scariv_csu_sched_ctrl;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_disp_valid;
  logic         o_disp_ready;
  logic [N-1:0] o_put;
  logic [N-1:0] o_out_ptr_valid;
  logic [N-1:0] i_entry_valid;
  logic [N-1:0] i_entry_ready;
  logic         i_pipe_stall;
  logic [N-1:0] o_entry_picked;
  logic         o_pick_valid;
  logic [2:0]   o_pick_idx;
  logic [N-1:0] i_issue_succeeded;
  logic [N-1:0] o_clear_entry;
  logic         o_credit_return;
  logic [3:0]   o_free_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  scariv_csu_sched_ctrl #(.ENTRY_SIZE(N)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_disp_valid      (i_disp_valid),
    .o_disp_ready      (o_disp_ready),
    .o_put             (o_put),
    .o_out_ptr_valid   (o_out_ptr_valid),
    .i_entry_valid     (i_entry_valid),
    .i_entry_ready     (i_entry_ready),
    .i_pipe_stall      (i_pipe_stall),
    .o_entry_picked    (o_entry_picked),
    .o_pick_valid      (o_pick_valid),
    .o_pick_idx        (o_pick_idx),
    .i_issue_succeeded (i_issue_succeeded),
    .o_clear_entry     (o_clear_entry),
    .o_credit_return   (o_credit_return),
    .o_free_cnt        (o_free_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit the current inputs at the edge, then leave 1 time unit for new stimulus.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_disp_valid      = 1'b0;
    i_entry_valid     = '0;
    i_entry_ready     = '0;
    i_pipe_stall      = 1'b0;
    i_issue_succeeded = '0;
  endtask

  function automatic logic [N-1:0] oh(input int idx);
    return N'(1) << (idx % N);
  endfunction

  initial begin
    i_reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    #1;
    check("rst_free",   o_free_cnt, 8);
    check("rst_ready",  o_disp_ready, 1);
    check("rst_outptr", o_out_ptr_valid, 8'h01);
    check("rst_put",    o_put, 0);
    check("rst_picked", o_entry_picked, 0);
    check("rst_clear",  o_clear_entry, 0);
    check("rst_credit", o_credit_return, 0);

    // Fill the array: the put strobe walks 0..7, then dispatch stalls.
    i_disp_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      #1;
      check($sformatf("fill_put%0d", k), o_put, oh(k));
      check($sformatf("fill_free%0d", k), o_free_cnt, 8 - k);
      tick();
    end
    #1;
    check("full_free",   o_free_cnt, 0);
    check("full_ready",  o_disp_ready, 0);
    check("full_no_put", o_put, 0);
    i_disp_valid = 1'b0;

    // A younger success must wait; the oldest success retires and returns a credit.
    i_issue_succeeded = 8'h04;
    #1;
    check("young_no_clear",  o_clear_entry, 0);
    check("young_no_credit", o_credit_return, 0);
    i_issue_succeeded = 8'h01;
    #1;
    check("old_clear",  o_clear_entry, 8'h01);
    check("old_credit", o_credit_return, 1);
    tick();
    i_issue_succeeded = '0;
    #1;
    check("retire_free", o_free_cnt, 1);
    check("retire_outptr", o_out_ptr_valid, 8'h02);

    // Pick with out index 1: entries 2 and 5 ready, 2 is older.
    i_entry_valid = 8'hff;
    i_entry_ready = 8'h24;
    #1;
    check("pick_o1_idx",   o_pick_idx, 2);
    check("pick_o1_oh",    o_entry_picked, 8'h04);
    check("pick_o1_valid", o_pick_valid, 1);
    i_entry_ready = '0;

    // Retire entries 1..3 in order, one per cycle.
    i_issue_succeeded = 8'h0e;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check($sformatf("ret_clear%0d", k), o_clear_entry, oh(k));
      tick();
    end
    i_issue_succeeded = '0;
    #1;
    check("ret3_free", o_free_cnt, 4);

    // Pick with out index 4, including the scan wrapping past index 7.
    i_entry_ready = 8'h24;
    #1;
    check("pick_o4_idx", o_pick_idx, 5);
    check("pick_o4_oh",  o_entry_picked, 8'h20);
    i_pipe_stall = 1'b1;
    #1;
    check("stall_valid", o_pick_valid, 0);
    check("stall_oh",    o_entry_picked, 0);
    i_pipe_stall  = 1'b0;
    i_entry_ready = 8'h42;
    #1;
    check("pick_o4_b_idx", o_pick_idx, 6);
    i_entry_ready = 8'h02;
    #1;
    check("pick_wrap_idx", o_pick_idx, 1);
    check("pick_wrap_oh",  o_entry_picked, 8'h02);
    i_entry_valid = 8'hfd;
    #1;
    check("pick_invalid", o_pick_valid, 0);
    i_entry_valid = '0;
    i_entry_ready = '0;

    // Refill indices 0..3 to full again.
    i_disp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("refill_put%0d", k), o_put, oh(k));
      tick();
    end
    #1;
    check("refull_ready", o_disp_ready, 0);

    // Full with a retire: no put this cycle, then steady alloc+retire across the wrap.
    i_issue_succeeded = 8'hff;
    #1;
    check("fullret_put",   o_put, 0);
    check("fullret_clear", o_clear_entry, 8'h10);
    tick();
    for (int j = 0; j < 5; j++) begin
      #1;
      check($sformatf("ar_put%0d", j),   o_put, oh(4 + j));
      check($sformatf("ar_clear%0d", j), o_clear_entry, oh(5 + j));
      check($sformatf("ar_free%0d", j),  o_free_cnt, 1);
      tick();
    end
    #1;
    check("ar_end_free", o_free_cnt, 1);
    check("ar_end_out",  o_out_ptr_valid, 8'h04);
    i_disp_valid = 1'b0;

    // Drain the 7 live entries (out 2..7,0); afterwards the empty guard blocks clears.
    for (int j = 0; j < 7; j++) begin
      #1;
      check($sformatf("drain_clear%0d", j), o_clear_entry, oh(2 + j));
      tick();
    end
    #1;
    check("empty_clear",  o_clear_entry, 0);
    check("empty_credit", o_credit_return, 0);
    check("empty_free",   o_free_cnt, 8);
    i_issue_succeeded = '0;

    // Five puts at indices 1..5, then all flush at once: one retire per cycle.
    i_disp_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("f5_put%0d", k), o_put, oh(k));
      tick();
    end
    i_disp_valid = 1'b0;
    i_issue_succeeded = 8'hff;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("flush_clear%0d", k), o_clear_entry, oh(k));
      check($sformatf("flush_credit%0d", k), o_credit_return, 1);
      tick();
    end
    #1;
    check("flush_done_clear", o_clear_entry, 0);
    check("flush_free", o_free_cnt, 8);
    i_issue_succeeded = '0;

    // Three live entries (6,7,0), then a one-cycle reset discards them.
    i_disp_valid = 1'b1;
    repeat (3) tick();
    i_disp_valid = 1'b0;
    #1;
    check("pre_rst_free", o_free_cnt, 5);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_issue_succeeded = 8'hff;
    #1;
    check("mid_rst_free",   o_free_cnt, 8);
    check("mid_rst_outptr", o_out_ptr_valid, 8'h01);
    check("mid_rst_clear",  o_clear_entry, 0);
    check("mid_rst_credit", o_credit_return, 0);
    check("mid_rst_put",    o_put, 0);
    check("mid_rst_ready",  o_disp_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_scariv_csu_sched_ctrl
